// File: rtl/if_pc_unit.sv
// if_pc_unit: instruction-fetch program-counter unit.
// Holds the architectural PC and computes the next fetch address from the
// ID-stage control word (next_pc_src, jmp_ctrl). Redirects resolve in ID and
// take effect one cycle after fetch, so the sequential instruction fetched
// behind a taken redirect is squashed through o_flush.
// Also owns the IDLE/RUN/HALTED fetch state machine used by the debug unit.
// Optional build macro: PC_UNIT_TRACE_EN adds saturating fetch and redirect
// counters (o_fetch_count, o_redirect_count).
module if_pc_unit #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [1:0]          JMP_NONE   = 2'b00,
  parameter logic [1:0]          JMP_DIR    = 2'b01,
  parameter logic [1:0]          JMP_REG    = 2'b10,
  parameter logic [1:0]          JMP_BRANCH = 2'b11
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_halt,
  input  logic                i_next_pc_src,
  input  logic [1:0]          i_jmp_ctrl,
  input  logic [25:0]         i_instr_index,
  input  logic [PC_WIDTH-1:0] i_bus_a,
  input  logic [PC_WIDTH-1:0] i_branch_offset,
  input  logic [PC_WIDTH-1:0] i_id_next_seq_pc,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_next_seq_pc,
  output logic                o_flush,
  output logic                o_running,
  output logic                o_halted,
  output logic                o_misaligned
`ifdef PC_UNIT_TRACE_EN
  ,
  output logic [31:0]         o_fetch_count,
  output logic [31:0]         o_redirect_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t              state;
  logic                adv;
  logic                halt_req;
  logic                redirect_req;
  logic                target_misaligned;
  logic                in_run;
  logic [PC_WIDTH-1:0] target;

  // Halt only counts while the debug unit lets the pipe advance; a stall
  // (or a frozen pipe) defers any redirect until ID re-presents it.
  assign in_run            = (state == ST_RUN);
  assign adv               = i_enable & ~i_stall;
  assign halt_req          = i_halt & i_enable;
  assign redirect_req      = adv & i_next_pc_src & (i_jmp_ctrl != JMP_NONE);
  assign target_misaligned = |target[1:0];

  assign o_next_seq_pc = o_pc + PC_WIDTH'(4);
  assign o_running     = (state == ST_RUN);
  assign o_halted      = (state == ST_HALTED);

  // Squash the wrong-path slot whenever a redirect is taken this cycle,
  // including the misaligned case that halts fetch.
  assign o_flush = in_run & ~halt_req & redirect_req;

  // Select the redirect target from the jump kind decoded in ID.
  always_comb begin
    target = i_id_next_seq_pc;
    case (i_jmp_ctrl)
      JMP_DIR:    target = {i_id_next_seq_pc[PC_WIDTH-1:28], i_instr_index, 2'b00};
      JMP_REG:    target = i_bus_a;
      JMP_BRANCH: target = i_id_next_seq_pc + (i_branch_offset << 2);
      default:    target = i_id_next_seq_pc;
    endcase
  end

  // Fetch state machine and PC register; priority is halt, hold, redirect, advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      o_pc         <= RESET_PC;
      o_misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state <= ST_HALTED;
          end else if (redirect_req) begin
            if (target_misaligned) begin
              o_misaligned <= 1'b1;
              state        <= ST_HALTED;
            end else begin
              o_pc <= target;
            end
          end else if (adv) begin
            o_pc <= o_pc + PC_WIDTH'(4);
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PC_UNIT_TRACE_EN
  logic fetch_evt;
  logic redirect_evt;

  assign redirect_evt = in_run & ~halt_req & redirect_req & ~target_misaligned;
  assign fetch_evt    = redirect_evt | (in_run & ~halt_req & adv & ~redirect_req);

  // Saturating trace counters for fetch progress and taken redirects.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fetch_count    <= '0;
      o_redirect_count <= '0;
    end else begin
      if (fetch_evt && (o_fetch_count != 32'hFFFF_FFFF)) begin
        o_fetch_count <= o_fetch_count + 32'd1;
      end
      if (redirect_evt && (o_redirect_count != 32'hFFFF_FFFF)) begin
        o_redirect_count <= o_redirect_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_unit.sv
// tb_if_pc_unit: self-checking bench for if_pc_unit (default build).
// Expected PC values are queued when a cycle is driven and compared after
// the clock edge that should produce them.
module tb_if_pc_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_enable;
  logic        i_stall;
  logic        i_halt;
  logic        i_next_pc_src;
  logic [1:0]  i_jmp_ctrl;
  logic [25:0] i_instr_index;
  logic [31:0] i_bus_a;
  logic [31:0] i_branch_offset;
  logic [31:0] i_id_next_seq_pc;
  logic [31:0] o_pc;
  logic [31:0] o_next_seq_pc;
  logic        o_flush;
  logic        o_running;
  logic        o_halted;
  logic        o_misaligned;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  if_pc_unit dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_enable         (i_enable),
    .i_stall          (i_stall),
    .i_halt           (i_halt),
    .i_next_pc_src    (i_next_pc_src),
    .i_jmp_ctrl       (i_jmp_ctrl),
    .i_instr_index    (i_instr_index),
    .i_bus_a          (i_bus_a),
    .i_branch_offset  (i_branch_offset),
    .i_id_next_seq_pc (i_id_next_seq_pc),
    .o_pc             (o_pc),
    .o_next_seq_pc    (o_next_seq_pc),
    .o_flush          (o_flush),
    .o_running        (o_running),
    .o_halted         (o_halted),
    .o_misaligned     (o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_ctrl();
    i_start          = 1'b0;
    i_stall          = 1'b0;
    i_halt           = 1'b0;
    i_next_pc_src    = 1'b0;
    i_jmp_ctrl       = 2'b00;
    i_instr_index    = '0;
    i_bus_a          = '0;
    i_branch_offset  = '0;
    i_id_next_seq_pc = '0;
  endtask

  task automatic test_reset();
    i_reset  = 1'b0;
    i_enable = 1'b0;
    clear_ctrl();
    #3;
    n_checks++;
    if (o_pc !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_pc: got %h expected %h", o_pc, 32'h0);
    end
    n_checks++;
    if ({o_running, o_halted, o_misaligned, o_flush} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {o_running, o_halted, o_misaligned, o_flush});
    end
    #4;
    i_reset = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_running !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_hold: got pc %h run %b expected pc %h run 0", o_pc, o_running, exp_pc);
    end
  endtask

  task automatic test_sequential();
    i_start  = 1'b1;
    i_enable = 1'b1;
    #1;
    n_checks++;
    if (o_flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_flush: got %b expected 0", o_flush);
    end
    exp_q.push_back(32'h0);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_running !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_pc: got pc %h run %b expected pc %h run 1", o_pc, o_running, exp_pc);
    end
    i_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if (o_flush !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL seq_flush[%0d]: got %b expected 0", i, o_flush);
      end
      exp_q.push_back(32'(4 * i));
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (o_pc !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, o_pc, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    i_next_pc_src    = 1'b1;
    i_jmp_ctrl       = 2'b11;
    i_id_next_seq_pc = 32'h0000_0020;
    i_branch_offset  = 32'hFFFF_FFFC;
    #1;
    n_checks++;
    if (o_flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL branch_flush: got %b expected 1", o_flush);
    end
    exp_q.push_back(32'h0000_0010);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL branch_pc: got %h expected %h", o_pc, exp_pc);
    end
    clear_ctrl();
    #1;
    n_checks++;
    if (o_flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_branch_flush: got %b expected 0", o_flush);
    end
    exp_q.push_back(32'h0000_0014);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL post_branch_pc: got %h expected %h", o_pc, exp_pc);
    end
  endtask

  task automatic test_misaligned();
    i_next_pc_src = 1'b1;
    i_jmp_ctrl    = 2'b10;
    i_bus_a       = 32'h0000_0102;
    #1;
    n_checks++;
    if (o_flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL misalign_flush: got %b expected 1", o_flush);
    end
    exp_q.push_back(32'h0000_0014);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL misalign_pc: got %h expected %h", o_pc, exp_pc);
    end
    n_checks++;
    if ({o_halted, o_misaligned, o_running} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL misalign_state: got %b expected 110", {o_halted, o_misaligned, o_running});
    end
    #1;
    n_checks++;
    if (o_flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL halted_flush: got %b expected 0", o_flush);
    end
    exp_q.push_back(32'h0000_0014);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_halted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL halted_hold: got pc %h halt %b expected pc %h halt 1", o_pc, o_halted, exp_pc);
    end
  endtask

  task automatic test_jr_aligned();
    clear_ctrl();
    i_reset = 1'b0;
    #2;
    n_checks++;
    if ({o_misaligned, o_halted} !== 2'b00 || o_pc !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rerun_reset: got mis/halt %b pc %h expected 00 pc 0", {o_misaligned, o_halted}, o_pc);
    end
    i_reset = 1'b1;
    i_start = 1'b1;
    tick();
    i_start       = 1'b0;
    i_next_pc_src = 1'b1;
    i_jmp_ctrl    = 2'b10;
    i_bus_a       = 32'h0000_0100;
    #1;
    n_checks++;
    if (o_flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL jr_flush: got %b expected 1", o_flush);
    end
    exp_q.push_back(32'h0000_0100);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_misaligned !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL jr_pc: got pc %h mis %b expected pc %h mis 0", o_pc, o_misaligned, exp_pc);
    end
  endtask

  task automatic test_stall_redirect();
    clear_ctrl();
    exp_q.push_back(32'h0000_0104);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL pre_stall_pc: got %h expected %h", o_pc, exp_pc);
    end
    i_stall          = 1'b1;
    i_next_pc_src    = 1'b1;
    i_jmp_ctrl       = 2'b01;
    i_instr_index    = 26'h40;
    i_id_next_seq_pc = 32'h0000_0108;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        i_stall  = 1'b0;
        i_enable = 1'b0;
      end
      #1;
      n_checks++;
      if (o_flush !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_flush[%0d]: got %b expected 0", i, o_flush);
      end
      exp_q.push_back(32'h0000_0104);
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (o_pc !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL stall_pc[%0d]: got %h expected %h", i, o_pc, exp_pc);
      end
    end
    i_enable = 1'b1;
    #1;
    n_checks++;
    if (o_flush !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL unstall_flush: got %b expected 1", o_flush);
    end
    exp_q.push_back(32'h0000_0100);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL unstall_pc: got %h expected %h", o_pc, exp_pc);
    end
  endtask

  task automatic test_dir_and_none();
    clear_ctrl();
    i_next_pc_src    = 1'b1;
    i_jmp_ctrl       = 2'b01;
    i_instr_index    = 26'h40;
    i_id_next_seq_pc = 32'hA000_0008;
    exp_q.push_back(32'hA000_0100);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL dir_upper_pc: got %h expected %h", o_pc, exp_pc);
    end
    i_jmp_ctrl = 2'b00;
    #1;
    n_checks++;
    if (o_flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL none_flush: got %b expected 0", o_flush);
    end
    exp_q.push_back(32'hA000_0104);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL none_pc: got %h expected %h", o_pc, exp_pc);
    end
  endtask

  task automatic test_wrap();
    clear_ctrl();
    i_next_pc_src = 1'b1;
    i_jmp_ctrl    = 2'b10;
    i_bus_a       = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_next_seq_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("[TB] FAIL wrap_setup: got pc %h nseq %h expected pc %h nseq fffffffc", o_pc, o_next_seq_pc, exp_pc);
    end
    clear_ctrl();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (o_pc !== exp_pc || o_next_seq_pc !== exp_pc + 32'd4) begin
        n_fail++;
        $display("[TB] FAIL wrap_pc[%0d]: got pc %h nseq %h expected pc %h nseq %h", i, o_pc, o_next_seq_pc, exp_pc, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_halt_redirect();
    clear_ctrl();
    exp_q.push_back(32'h0000_0004);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL pre_halt_pc: got %h expected %h", o_pc, exp_pc);
    end
    i_halt           = 1'b1;
    i_next_pc_src    = 1'b1;
    i_jmp_ctrl       = 2'b11;
    i_id_next_seq_pc = 32'h0000_0008;
    i_branch_offset  = 32'h0000_0004;
    #1;
    n_checks++;
    if (o_flush !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL halt_flush: got %b expected 0", o_flush);
    end
    exp_q.push_back(32'h0000_0004);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || {o_halted, o_running, o_misaligned} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL halt_state: got pc %h hrm %b expected pc %h hrm 100", o_pc, {o_halted, o_running, o_misaligned}, exp_pc);
    end
    i_halt  = 1'b0;
    i_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (o_flush !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL halted_ignore_flush[%0d]: got %b expected 0", i, o_flush);
      end
      exp_q.push_back(32'h0000_0004);
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (o_pc !== exp_pc || o_halted !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL halted_ignore[%0d]: got pc %h halt %b expected pc %h halt 1", i, o_pc, o_halted, exp_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_ctrl();
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (o_pc !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL pre_areset_pc[%0d]: got %h expected %h", i, o_pc, exp_pc);
      end
    end
    #3;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (o_pc !== 32'h0 || {o_running, o_halted, o_misaligned} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got pc %h rhm %b expected pc 0 rhm 000", o_pc, {o_running, o_halted, o_misaligned});
    end
    #2;
    i_reset = 1'b1;
    i_start = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    i_start = 1'b0;
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc || o_running !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL restart: got pc %h run %b expected pc %h run 1", o_pc, o_running, exp_pc);
    end
    exp_q.push_back(32'h0000_0004);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (o_pc !== exp_pc) begin
      n_fail++;
      $display("[TB] FAIL restart_seq: got %h expected %h", o_pc, exp_pc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_jr_aligned();
    test_stall_redirect();
    test_dir_and_none();
    test_wrap();
    test_halt_redirect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- Instruction-fetch program-counter unit.
- Holds the architectural PC and drives the instruction-memory address.
- Computes the next PC from the control word produced by the ID-stage main control: bit 19 `next_pc_src`, bits 18:17 `jmp_ctrl`.
- Branches and jumps resolve in ID, so this unit applies redirects one cycle after fetch and squashes the wrong-path instruction in IF/ID.
- Also owns the fetch run/halt state machine used by the debug unit.

Parameters:
- PC_WIDTH, 32, PC and data-bus width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- JMP_NONE, 2'b00, `jmp_ctrl` code: no jump.
- JMP_DIR, 2'b01, `jmp_ctrl` code: direct jump (J/JAL).
- JMP_REG, 2'b10, `jmp_ctrl` code: register jump (JR/JALR).
- JMP_BRANCH, 2'b11, `jmp_ctrl` code: taken conditional branch.

Ports:
- i_clk, input, 1, system clock, rising edge.
- i_reset, input, 1, asynchronous active-low reset.
- i_start, input, 1, leave IDLE and begin fetching.
- i_enable, input, 1, global advance enable from the debug unit (step/continuous); 0 freezes the PC.
- i_stall, input, 1, hazard stall from ID (load-use); holds the PC.
- i_halt, input, 1, HALT instruction decoded in ID.
- i_next_pc_src, input, 1, control-word bit 19: 1 = non-sequential.
- i_jmp_ctrl, input, 2, control-word bits 18:17.
- i_instr_index, input, 26, J-type index field of the ID instruction.
- i_bus_a, input, PC_WIDTH, rs value (forwarded) for JR/JALR.
- i_branch_offset, input, PC_WIDTH, sign-extended 16-bit immediate of the ID instruction.
- i_id_next_seq_pc, input, PC_WIDTH, PC+4 of the instruction in ID.
- o_pc, output, PC_WIDTH, current fetch address.
- o_next_seq_pc, output, PC_WIDTH, o_pc + 4 (combinational), stored in IF/ID.
- o_flush, output, 1, squash IF/ID contents (load NOP) on the next edge.
- o_running, output, 1, state == RUN.
- o_halted, output, 1, state == HALTED.
- o_misaligned, output, 1, sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, i_reset=0) sets:
  - o_pc = RESET_PC
  - state = IDLE
  - o_flush = 0, o_halted = 0, o_misaligned = 0
- States: IDLE, RUN, HALTED (one-hot or binary, implementer's choice).
- IDLE:
  - PC held; o_flush = 0.
  - i_start = 1 → RUN next edge. The first fetch uses RESET_PC.
- RUN: define `adv = i_enable & ~i_stall`. Per-cycle priority is:
  1. `i_halt & i_enable` → HALTED; PC held; o_flush = 0. The instructions already in the pipe drain normally. Halt wins over a simultaneous redirect or stall.
  2. `~adv` → PC held, o_flush = 0. A pending redirect is ignored; ID re-presents it once the stall clears.
  3. Redirect, when `adv & i_next_pc_src & (i_jmp_ctrl != JMP_NONE)`. Target by `i_jmp_ctrl`:
     - JMP_DIR: {i_id_next_seq_pc[31:28], i_instr_index, 2'b00}
     - JMP_REG: i_bus_a
     - JMP_BRANCH: i_id_next_seq_pc + (i_branch_offset << 2), modulo 2^32
     - If target[1:0] == 2'b00: o_pc <= target, and o_flush = 1 (combinational, same cycle) to kill the sequential instruction fetched behind the branch.
     - If target[1:0] != 0: o_misaligned <= 1, state → HALTED, PC held, o_flush = 1.
  4. Otherwise, if `adv`: o_pc <= o_pc + 4. Wraps 32'hFFFF_FFFC → 32'h0000_0000 silently.
  5. The combination `i_next_pc_src = 1` with `i_jmp_ctrl = JMP_NONE` is treated as sequential, no flush.
- HALTED:
  - PC held; o_flush = 0; inputs ignored.
  - Exit only by reset.
  - o_misaligned stays set until reset.
- o_flush is purely combinational from the current inputs and state. It is 0 in IDLE and HALTED.
- Latency: redirect decision in cycle N → target on o_pc after edge N. Exactly one wrong-path slot is flushed.
- i_start is ignored outside IDLE.

Optional Feature:
- Macro: PC_UNIT_TRACE_EN.
- When defined, adds two free-running 32-bit counters, cleared on reset:
  - o_fetch_count: increments on every cycle the PC advances or redirects.
  - o_redirect_count: increments on each accepted aligned redirect.
- Both counters saturate at 32'hFFFF_FFFF.
- When not defined: ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then i_start=1, i_enable=1, 4 cycles of no control → o_pc sequence 0x0, 0x4, 0x8, 0xC, 0x10; o_flush always 0.
- Branch: i_next_pc_src=1, i_jmp_ctrl=11, i_id_next_seq_pc=0x20, i_branch_offset=0xFFFF_FFFC → o_flush=1 that cycle; o_pc=0x10 next.
- JR to 0x102 → o_misaligned=1, o_halted=1, o_pc unchanged; JR to 0x100 in a fresh run → o_pc=0x100.
- i_stall=1 concurrent with a JMP_DIR redirect (index 0x40) → o_pc held, o_flush=0; stall drops → o_pc=0x100 (upper bits 0), o_flush=1.
- i_halt=1 together with a branch redirect → HALTED, o_pc held, o_flush=0; further i_start and redirects have no effect.
- Async reset asserted mid-RUN between clock edges → o_pc=RESET_PC immediately, state IDLE; o_misaligned cleared.
